// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver for the Apple-1 terminal input side.
// Receives scan-code set 2 frames, tracks shift and make/break state, and maps
// keys to upper-case 7-bit ASCII. The result is exposed as the KBD data
// register (address 0) and the KBDCR status register (address 1).
//
// Ports:
//   clk25     - 25 MHz system clock
//   rst       - synchronous active-high reset
//   ps2_clk   - raw PS/2 clock (asynchronous)
//   ps2_din   - raw PS/2 data (asynchronous)
//   enable    - CPU clock-enable strobe
//   r_en      - CPU read strobe
//   address   - 0: KBD data, 1: KBDCR status
//   dout      - registered read data (1-cycle latency)
//   key_ready - unread key available (KBDCR bit 7)
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       enable,
  input  logic       r_en,
  input  logic       address,
  output logic [7:0] dout,
  output logic       key_ready
);

  localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]            clk_sync_q, clk_sync_d, din_sync_q, din_sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  fall, din_s;

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic                  code_valid_q, code_valid_d;
  logic [7:0]            code_q, code_d;

  logic                  break_q, break_d, ext_q, ext_d, shift_q, shift_d;
  logic [6:0]            key_q, key_d;
  logic                  key_ready_q, key_ready_d;
  logic [7:0]            dout_q, dout_d;
  logic                  map_hit, load;
  logic [6:0]            map_char;

  // Synchroniser and glitch filter on the PS/2 clock.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    din_sync_d = {din_sync_q[0], ps2_din};
    hist_d     = {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d     = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (hist_q == '0) begin
      filt_d = 1'b0;
    end
    fall  = filt_q & ~filt_d;
    din_s = din_sync_q[1];
  end

  // Frame FSM with mid-frame timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    code_valid_d = 1'b0;
    code_d       = code_q;
    to_cnt_d     = (state_q == StIdle || fall) ? '0 : to_cnt_q + ToW'(1);

    unique case (state_q)
      StIdle: begin
        if (fall && !din_s) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall) begin
          shreg_d   = {din_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = din_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (din_s && (^{shreg_q, par_q})) begin
            code_valid_d = 1'b1;
            code_d       = shreg_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A fall in the same cycle restarts the count instead of timing out.
    if (state_q != StIdle && !fall && to_cnt_q == ToMax) begin
      state_d  = StIdle;
      to_cnt_d = '0;
    end
  end

  // Scan code to ASCII; letters ignore shift.
  always_comb begin
    map_hit  = 1'b1;
    map_char = 7'h00;
    case (code_q)
      8'h1C: map_char = 7'h41;
      8'h32: map_char = 7'h42;
      8'h21: map_char = 7'h43;
      8'h23: map_char = 7'h44;
      8'h24: map_char = 7'h45;
      8'h2B: map_char = 7'h46;
      8'h34: map_char = 7'h47;
      8'h33: map_char = 7'h48;
      8'h43: map_char = 7'h49;
      8'h3B: map_char = 7'h4A;
      8'h42: map_char = 7'h4B;
      8'h4B: map_char = 7'h4C;
      8'h3A: map_char = 7'h4D;
      8'h31: map_char = 7'h4E;
      8'h44: map_char = 7'h4F;
      8'h4D: map_char = 7'h50;
      8'h15: map_char = 7'h51;
      8'h2D: map_char = 7'h52;
      8'h1B: map_char = 7'h53;
      8'h2C: map_char = 7'h54;
      8'h3C: map_char = 7'h55;
      8'h2A: map_char = 7'h56;
      8'h1D: map_char = 7'h57;
      8'h22: map_char = 7'h58;
      8'h35: map_char = 7'h59;
      8'h1A: map_char = 7'h5A;
      8'h45: map_char = shift_q ? 7'h29 : 7'h30;
      8'h16: map_char = shift_q ? 7'h21 : 7'h31;
      8'h1E: map_char = shift_q ? 7'h40 : 7'h32;
      8'h26: map_char = shift_q ? 7'h23 : 7'h33;
      8'h25: map_char = shift_q ? 7'h24 : 7'h34;
      8'h2E: map_char = shift_q ? 7'h25 : 7'h35;
      8'h36: map_char = shift_q ? 7'h5E : 7'h36;
      8'h3D: map_char = shift_q ? 7'h26 : 7'h37;
      8'h3E: map_char = shift_q ? 7'h2A : 7'h38;
      8'h46: map_char = shift_q ? 7'h28 : 7'h39;
      8'h41: map_char = shift_q ? 7'h3C : 7'h2C;
      8'h49: map_char = shift_q ? 7'h3E : 7'h2E;
      8'h4A: map_char = shift_q ? 7'h3F : 7'h2F;
      8'h4C: map_char = shift_q ? 7'h3A : 7'h3B;
      8'h52: map_char = shift_q ? 7'h22 : 7'h27;
      8'h4E: map_char = shift_q ? 7'h5F : 7'h2D;
      8'h55: map_char = shift_q ? 7'h2B : 7'h3D;
      8'h29: map_char = 7'h20;
      8'h5A: map_char = 7'h0D;
      8'h66: map_char = 7'h5F;
      8'h76: map_char = 7'h1B;
      default: map_hit = 1'b0;
    endcase
  end

  // Make/break/extended decoding, key register and CPU read port.
  always_comb begin
    break_d = break_q;
    ext_d   = ext_q;
    shift_d = shift_q;
    key_d   = key_q;
    load    = 1'b0;
    if (code_valid_q) begin
      if (code_q == 8'hF0) begin
        break_d = 1'b1;
      end else if (code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        break_d = 1'b0;
        ext_d   = 1'b0;
        if (!ext_q) begin
          if (code_q == 8'h12 || code_q == 8'h59) begin
            shift_d = ~break_q;
          end else if (!break_q && map_hit) begin
            key_d = map_char;
            load  = 1'b1;
          end
        end
      end
    end
    // A key arriving with a clearing read wins, so the new key is not lost.
    key_ready_d = key_ready_q;
    if (load) begin
      key_ready_d = 1'b1;
    end else if (enable && r_en && !address) begin
      key_ready_d = 1'b0;
    end
    dout_d = address ? {key_ready_q, 7'b0} : {1'b1, key_q};
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      din_sync_q   <= 2'b11;
      hist_q       <= '1;
      filt_q       <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      code_valid_q <= 1'b0;
      code_q       <= 8'h00;
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      shift_q      <= 1'b0;
      key_q        <= 7'h00;
      key_ready_q  <= 1'b0;
      dout_q       <= 8'h00;
    end else begin
      clk_sync_q   <= clk_sync_d;
      din_sync_q   <= din_sync_d;
      hist_q       <= hist_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      code_valid_q <= code_valid_d;
      code_q       <= code_d;
      break_q      <= break_d;
      ext_q        <= ext_d;
      shift_q      <= shift_d;
      key_q        <= key_d;
      key_ready_q  <= key_ready_d;
      dout_q       <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign key_ready = key_ready_q;

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Keyboard input side of the Apple-1 terminal; the display block is the output side.
- Receives PS/2 scan-code set 2 frames from a US keyboard and tracks make/break and shift state.
- Translates keys to upper-case 7-bit ASCII and presents them to the 6502 as the KBD data register ($D010) and KBDCR status register ($D011).
- Sits beside the display block on the clk25 domain, selected by the same address-decode bit.

Parameters:
- FILTER_LEN, 8: number of consecutive identical ps2_clk samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 25000: clk25 cycles (1 ms) without a filtered falling edge mid-frame before the frame is abandoned.

Ports:
- clk25  input  1  system clock, 25 MHz.
- rst  input  1  reset; synchronous, active-high.
- ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous.
- ps2_din  input  1  raw PS/2 data from the connector, asynchronous.
- enable  input  1  CPU clock-enable strobe.
- r_en  input  1  CPU read strobe; active high.
- address  input  1  0 = KBD data register, 1 = KBDCR status register.
- dout  output  8  register read data.
- key_ready  output  1  unread key available; mirrors KBDCR bit 7.

Behaviour:
- Reset (synchronous, rst high at a clk25 edge):
  - dout=0, key_ready=0, key register=0.
  - Frame FSM to IDLE; shift and ext flags cleared; break pending cleared; timeout counter=0.
  - Filter history set to all ones, so the filtered clock reads high.
  - A frame in progress when rst asserts is discarded.
- Synchroniser: ps2_clk and ps2_din each pass through 2 flops.
- Filter:
  - FILTER_LEN-deep shift register on the synchronised ps2_clk.
  - Filtered level goes 0 when all samples are 0 and goes 1 when all samples are 1; otherwise it holds.
  - fall = filtered level 1->0. Data is sampled on the cycle fall is detected.
- Frame FSM:
  - IDLE: on fall with data=0 (start bit), go to DATA with bit count=0. A start bit of 1 is ignored; stay IDLE.
  - DATA: on each fall, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit, then go to STOP.
  - STOP: on fall, the frame is accepted only if stop=1 and odd parity holds over the 8 data bits plus parity. Accepted frames pulse code_valid for 1 cycle with code[7:0]. Return to IDLE either way.
  - Timeout: the counter runs in every state except IDLE and resets on each fall. Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE with no code_valid.
- Decoder, on code_valid:
  - F0: set break_pend.
  - E0: set ext_pend.
  - Otherwise the code is a key event: break = break_pend, extended = ext_pend. Both pend flags clear.
  - Extended events are ignored entirely.
  - 0x12 and 0x59 (L/R shift): shift = ~break.
  - Break events of non-shift keys are ignored.
  - Make events go through the map below. A mapped key loads key[6:0] and sets key_ready. Unmapped codes are dropped.
- Map:
  - Letters produce upper case regardless of shift: 1C->'A'(0x41), 32->'B', 21->'C', 23->'D', 24->'E', 2B->'F', 34->'G', 33->'H', 43->'I', 3B->'J', 42->'K', 4B->'L', 3A->'M', 31->'N', 44->'O', 4D->'P', 15->'Q', 2D->'R', 1B->'S', 2C->'T', 3C->'U', 2A->'V', 1D->'W', 22->'X', 35->'Y', 1A->'Z'.
  - Digits, unshifted then shifted: 45 0/), 16 1/!, 1E 2/@, 26 3/#, 25 4/$, 2E 5/%, 36 6/^, 3D 7/&, 3E 8/*, 46 9/(.
  - Punctuation, unshifted then shifted: 41 ,/<, 49 ./>, 4A //?, 4C ;/:, 52 '/", 4E -/_, 55 =/+.
  - Other keys: 29 space 0x20, 5A CR 0x0D, 66 backspace -> '_' 0x5F, 76 ESC 0x1B.
- Latency: key_ready rises exactly 2 clk25 cycles after the cycle in which the stop-bit fall is detected (code_valid, then key load).
- CPU interface:
  - A read occurs when enable & r_en are both high.
  - dout is registered every cycle, 1-cycle latency. address=0 gives {1'b1, key[6:0]}; address=1 gives {key_ready, 7'b0}.
  - A read with address=0 clears key_ready on the next edge. A read with address=1 has no side effect.
- Simultaneous events:
  - A key load in the same cycle as a clearing read leaves key_ready=1 with the new key.
  - A new key while key_ready=1 overwrites key (overrun); there is no flag.
- Shift state persists across frames. Only rst clears it.

Test Plan:
- Frame 1C (start 0, data LSB-first, parity 0, stop 1) at 10 kHz -> key_ready=1 two cycles after stop fall; address=0 read gives dout=0xC1; next address=1 read gives 0x00.
- Sequence 12, 16, F0 16, F0 12, 16 -> first key 0xA1 ('!'); after reading it, second key 0xB1 ('1'); break codes produce no key.
- Frame 5A with parity bit flipped -> no key_ready; next valid 5A -> dout 0x8D.
- Send 5 bits of a frame, idle 1.2 ms, then a full frame 29 -> partial frame discarded; key 0xA0.
- E0 75 (up arrow), then 66 -> only 0xDF delivered; glitch pulses of 4 cycles on ps2_clk cause no bit shift.
- Assert rst mid-frame, then send 1C -> key_ready=0 during rst; afterwards a clean 0xC1. A key load in the same cycle as a clearing read keeps key_ready=1.
